// File: rtl/guvm_instr_feeder.sv
// Instruction-side fetch responder: queues pushed instruction words and answers core fetches in order.
// Optional macro GUVM_FEEDER_NOP_FILL_EN: grant on an empty FIFO and return NOP_INSTR.
module guvm_instr_feeder #(
    parameter int DEPTH = 8,
    parameter int INSTR_RDATA_WIDTH = 32,
    parameter logic [INSTR_RDATA_WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_valid_i,
    output logic                           push_ready_o,
    input  logic [INSTR_RDATA_WIDTH-1:0]   push_instr_i,
    input  logic                           flush_i,
    input  logic                           instr_req_i,
    input  logic [31:0]                    instr_addr_i,
    output logic                           instr_gnt_o,
    output logic                           instr_rvalid_o,
    output logic [INSTR_RDATA_WIDTH-1:0]   instr_rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]     fill_level_o,
    output logic [31:0]                    fetch_count_o,
    output logic [31:0]                    resp_addr_o,
    output logic                           resp_state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(DEPTH + 1);

`ifdef GUVM_FEEDER_NOP_FILL_EN
    localparam bit NOP_FILL = 1'b1;
`else
    localparam bit NOP_FILL = 1'b0;
`endif

    typedef enum logic {
        RESP_IDLE  = 1'b0,
        RESP_VALID = 1'b1
    } resp_state_e;

    resp_state_e state, state_next;

    logic [PW-1:0]                  wptr, rptr;
    logic [INSTR_RDATA_WIDTH-1:0]   mem [DEPTH];
    logic                           empty, full, gnt, pop, push;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // Handshakes: a push transfers on push_valid_i && push_ready_o at the edge; a fetch
    // transfers on instr_req_i && instr_gnt_o and is answered by rvalid exactly one cycle later.
    assign gnt  = instr_req_i && (!empty || NOP_FILL);
    assign pop  = gnt && !empty;
    assign push = push_valid_i && !full && !flush_i;

    assign push_ready_o   = !full;
    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = (state == RESP_VALID);
    assign fill_level_o   = LW'(wptr - rptr);
    assign resp_state_o   = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr[AW-1:0]] <= push_instr_i;
    end

    // Response register captures the pre-flush head, so a grant alongside flush still answers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= RESP_IDLE;
            instr_rdata_o <= '0;
            resp_addr_o   <= '0;
            fetch_count_o <= '0;
        end else begin
            state <= state_next;
            if (gnt) begin
                instr_rdata_o <= empty ? NOP_INSTR : mem[rptr[AW-1:0]];
                resp_addr_o   <= instr_addr_i;
                if (fetch_count_o != 32'hFFFF_FFFF) fetch_count_o <= fetch_count_o + 32'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RESP_IDLE:  state_next = gnt ? RESP_VALID : RESP_IDLE;
            RESP_VALID: state_next = gnt ? RESP_VALID : RESP_IDLE;
            default:    state_next = RESP_IDLE;
        endcase
    end

endmodule

// File: tb/tb_guvm_instr_feeder.sv
// Randomized bench for guvm_instr_feeder: a queue-based reference model predicts grants and
// responses; a negedge monitor pops the expected-response queue whenever a response is due.
module tb_guvm_instr_feeder;
    localparam int DEPTH = 8;
    localparam int W = 32;
    localparam logic [W-1:0] NOP = 32'h00000013;
`ifdef GUVM_FEEDER_NOP_FILL_EN
    localparam bit NOP_FILL = 1'b1;
`else
    localparam bit NOP_FILL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic [W-1:0]  push_instr = '0;
    logic          flush = 1'b0;
    logic          instr_req = 1'b0;
    logic [31:0]   instr_addr = '0;
    logic          instr_gnt;
    logic          instr_rvalid;
    logic [W-1:0]  instr_rdata;
    logic [3:0]    fill_level;
    logic [31:0]   fetch_count;
    logic [31:0]   resp_addr;
    logic          resp_state;

    guvm_instr_feeder #(.DEPTH(DEPTH), .INSTR_RDATA_WIDTH(W), .NOP_INSTR(NOP)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .push_valid_i(push_valid), .push_ready_o(push_ready), .push_instr_i(push_instr),
        .flush_i(flush),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
        .fill_level_o(fill_level), .fetch_count_o(fetch_count), .resp_addr_o(resp_addr),
        .resp_state_o(resp_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [W-1:0]  model_q [$];
    logic [63:0]   exp_q [$];
    int unsigned   model_count = 0;
    logic [W-1:0]  last_rdata = '0;
    logic [31:0]   last_addr = '0;
    bit            in_reset = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Called at posedge+2; leaves at posedge+2 with the DUT out of reset.
    task automatic do_reset();
        in_reset = 1'b1;
        rst_n = 1'b0;
        push_valid = 1'b0; instr_req = 1'b0; flush = 1'b0;
        exp_q.delete();
        model_q.delete();
        model_count = 0;
        last_rdata = '0;
        last_addr = '0;
        #1;
        check("rst_rvalid", instr_rvalid, 0);
        check("rst_gnt", instr_gnt, 0);
        check("rst_ready", push_ready, 1);
        check("rst_rdata", instr_rdata, 0);
        check("rst_fill", fill_level, 0);
        check("rst_count", fetch_count, 0);
        check("rst_addr", resp_addr, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 in_reset = 1'b0;
    endtask

    // driver: one clock cycle of stimulus, plus the reference-model update at the edge
    task automatic step(input bit pv, input logic [W-1:0] w, input bit rq, input bit fl);
        int pre;
        bit exp_gnt, accept;
        logic [31:0] a;
        logic [W-1:0] hw;
        a = $urandom;
        push_valid = pv; push_instr = w; instr_req = rq; instr_addr = a; flush = fl;
        #2;
        pre = model_q.size();
        exp_gnt = rq && (pre > 0 || NOP_FILL);
        accept = pv && (pre < DEPTH);
        check("push_ready", push_ready, 64'(pre < DEPTH));
        check("fill_level", fill_level, 64'(pre));
        check("gnt", instr_gnt, 64'(exp_gnt));
        check("fetch_count", fetch_count, 64'(model_count));
        @(posedge clk);
        if (exp_gnt) begin
            if (pre > 0) hw = model_q.pop_front();
            else hw = NOP;
            exp_q.push_back({a, hw});
            if (model_count != 32'hFFFF_FFFF) model_count++;
        end
        if (fl) model_q.delete();
        else if (accept) model_q.push_back(w);
        #2;
    endtask

    task automatic drain();
        repeat (DEPTH + 1) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    // monitor: a response is due exactly when the last edge produced a grant
    always @(negedge clk) begin
        if (!in_reset) begin
            logic [63:0] e;
            bit exp_v;
            exp_v = (exp_q.size() > 0);
            check("rvalid", instr_rvalid, 64'(exp_v));
            if (exp_v) begin
                e = exp_q.pop_front();
                check("rdata", instr_rdata, e[31:0]);
                check("resp_addr", resp_addr, e[63:32]);
                last_rdata = e[31:0];
                last_addr = e[63:32];
            end else if (!instr_rvalid) begin
                check("rdata_hold", instr_rdata, last_rdata);
                check("addr_hold", resp_addr, last_addr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        do_reset();

        // in-order delivery with request held
        step(1'b1, 32'h00208033, 1'b1, 1'b0);
        step(1'b1, 32'h00310133, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // fill to the brim, ninth push refused, then back-to-back fetches
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // empty FIFO with request, then a push becomes grantable one cycle later
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'hCAFE0001, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        drain();

        // full FIFO: pop proceeds, same-cycle push refused
        for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD0004, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        drain();

        // flush together with a grant still answers with the old head
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b1, 32'hF1F1F1F1, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 24) == 0));
        drain();

        // reset while a response is pending
        step(1'b1, 32'h11111111, 1'b0, 1'b0);
        step(1'b1, 32'h22222222, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        do_reset();
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 32'h33333333, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        check("exp_q_empty", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
